// File: rtl/or_unit_arbiter.sv
// or_unit_arbiter: shares one registered bitwise-OR unit among NREQ requesters.
// Requesters offer (a, b) over valid/ready. At most one pair is granted per
// cycle, a | b is captured in a single result register, and the result leaves
// tagged with the requester index over a downstream valid/ready handshake.
//
// Build option: define OR_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Default build is round-robin.
//
// Output stage FSM:
//   state   | meaning
//   S_EMPTY | result register holds nothing, res_valid = 0
//   S_FULL  | result register holds an unconsumed result, res_valid = 1
module or_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [IDW-1:0]    res_id_q, res_id_d;

  logic [IDW-1:0]    scan_base;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [WIDTH-1:0]  grant_or;
  logic              can_accept;
  logic              xfer;

  // Position `off` steps after `base`, wrapping modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] scan_pos(input logic [IDW-1:0] base, input int off);
    int p;
    p = int'(base) + off;
    if (p >= NREQ) p = p - NREQ;
    return IDW'(p);
  endfunction

`ifdef OR_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  assign scan_base = rr_ptr_q;

  // Pointer moves to the slot after the winner, only when a transfer happens.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Find the first valid requester starting at scan_base, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[scan_pos(scan_base, k)]) begin
        grant_found = 1'b1;
        grant_idx   = scan_pos(scan_base, k);
      end
    end
  end

  // Select the winner's operand pair and OR it.
  always_comb begin
    grant_or = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_or = req_a[i*WIDTH +: WIDTH] | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign can_accept = (state_q == S_EMPTY) || res_ready;

  // One-hot grant, suppressed during reset and while the result is stalled.
  always_comb begin
    req_ready = '0;
    if (!reset && can_accept && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Output-stage next state: load on transfer, drain on res_ready, else hold.
  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    case (state_q)
      S_EMPTY: begin
        if (xfer) state_d = S_FULL;
      end
      S_FULL: begin
        if (xfer) begin
          state_d = S_FULL;
        end else if (res_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (xfer) begin
      res_data_d = grant_or;
      res_id_d   = grant_idx;
    end
  end

  // Output-stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_valid = (state_q == S_FULL);
  assign busy      = res_valid;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Directed bench for or_unit_arbiter (NREQ=4, WIDTH=8). Expected results are
// queued when a grant is expected and compared when the result is consumed.
module tb_or_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
`ifdef OR_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [7:0]            opa [NREQ];
  logic [7:0]            opb [NREQ];
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready = 1'b1;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  assign req_a = {opa[3], opa[2], opa[1], opa[0]};
  assign req_b = {opb[3], opb[2], opb[1], opb[0]};

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  or_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check the grant and queue the result it should produce.
  task automatic grant(input int g, input string tag);
    logic [31:0] exp_rdy;
    exp_t        e;
    exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
    chk(tag, {28'd0, req_ready}, exp_rdy);
    if (g >= 0) begin
      e.id   = 2'(g);
      e.data = opa[g] | opb[g];
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted result must match the oldest queued one.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("res_data", {24'd0, res_data}, {24'd0, e.data});
        chk("res_id", {30'd0, res_id}, {30'd0, e.id});
      end
    end
  end

  initial begin
    int         g;
    logic [7:0] exp_bp;

    opa[0] = 8'h01; opb[0] = 8'h10;
    opa[1] = 8'h22; opb[1] = 8'h04;
    opa[2] = 8'h40; opb[2] = 8'h08;
    opa[3] = 8'h83; opb[3] = 8'h30;

    // Reset held for two cycles with all requests pending.
    reset = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_data", {24'd0, res_data}, 32'd0);
      chk("rst_id", {30'd0, res_id}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    drive_edge();
    reset = 1'b0;

    // Fairness: all four valid for eight cycles.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = FIXED ? 0 : (k % 4);
      grant(g, "rr_grant");
      if (k > 0) chk("rr_b2b_valid", {31'd0, res_valid}, 32'd1);
      drive_edge();
      opa[g] = 8'($urandom);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rr_last_valid", {31'd0, res_valid}, 32'd1);
    grant(-1, "idle_ready");
    drive_edge();
    @(negedge clk);
    chk("rr_drained", {31'd0, res_valid}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);

    // Single request from requester 2.
    drive_edge();
    opa[2] = 8'hA0; opb[2] = 8'h0C; req_valid = 4'b0100;
    @(negedge clk);
    grant(2, "single_grant");
    drive_edge();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", {31'd0, res_valid}, 32'd1);
    chk("single_data", {24'd0, res_data}, 32'h0000_00AC);
    chk("single_id", {30'd0, res_id}, 32'd2);
    chk("single_busy", {31'd0, busy}, 32'd1);
    drive_edge();
    @(negedge clk);
    chk("single_drain", {31'd0, res_valid}, 32'd0);

    // Wrap/skip: pointer at 3, only requester 1 valid, then 3, then 0 and 3.
    drive_edge();
    req_valid = 4'b0010;
    @(negedge clk);
    grant(1, "skip_grant1");
    drive_edge();
    req_valid = 4'b1000;
    @(negedge clk);
    grant(3, "wrap_grant3");
    drive_edge();
    req_valid = 4'b1001;
    @(negedge clk);
    grant(0, "wrap_ptr0");

    // Backpressure: load 8'h5A from requester 1, then stall with requests pending.
    drive_edge();
    opa[1] = 8'h50; opb[1] = 8'h0A; req_valid = 4'b1010;
    @(negedge clk);
    grant(1, "bp_load");
    drive_edge();
    res_ready = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", {24'd0, res_data}, 32'h0000_005A);
      chk("bp_id", {30'd0, res_id}, 32'd1);
      drive_edge();
    end
    res_ready = 1'b1;
    @(negedge clk);
    g = FIXED ? 0 : 2;
    exp_bp = opa[g] | opb[g];
    grant(g, "bp_release");
    drive_edge();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("bp_new_valid", {31'd0, res_valid}, 32'd1);
    chk("bp_new_data", {24'd0, res_data}, {24'd0, exp_bp});
    chk("bp_new_id", {30'd0, res_id}, 32'(g));
    drive_edge();

    // Reset mid-flight: pointer moved to 3 with a stalled result, then reset.
    res_ready = 1'b0; req_valid = 4'b0100;
    @(negedge clk);
    grant(2, "mf_load");
    drive_edge();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("mf_full", {31'd0, res_valid}, 32'd1);
    drive_edge();
    reset = 1'b1; req_valid = 4'b1111;
    @(negedge clk);
    chk("mf_rst_ready", {28'd0, req_ready}, 32'd0);
    sb_q.delete();
    drive_edge();
    reset = 1'b0; req_valid = 4'b1001; res_ready = 1'b1;
    @(negedge clk);
    chk("mf_dropped", {31'd0, res_valid}, 32'd0);
    grant(0, "mf_ptr_reset");
    drive_edge();
    req_valid = 4'b1000;
    @(negedge clk);
    grant(3, "mf_grant3");
    drive_edge();
    req_valid = 4'b0000;
    @(negedge clk);
    drive_edge();
    @(negedge clk);
    chk("end_valid", {31'd0, res_valid}, 32'd0);
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/or_unit_arbiter.md
# or_unit_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise-OR unit among `NREQ` requesters. Each requester offers an operand pair over a valid/ready handshake; the block grants at most one request per cycle and computes `a | b` in a single register stage. It returns the result tagged with the requester index over a downstream valid/ready handshake. It sits between the requesting datapath blocks and their consumer, replacing per-requester OR gates with one shared, scheduled unit.

## Interface
- `NREQ`, 4, number of requesters, 2..16
- `WIDTH`, 8, operand/result width in bits, ≥1
- `IDW`, derived localparam = clog2(`NREQ`), result tag width
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; clock `clk`
- `req_valid`  in  NREQ  bit i: requester i offers a pair
- `req_a`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  operand B, same packing
- `req_ready`  out  NREQ  bit i: requester i granted this cycle (one-hot or zero)
- `res_valid`  out  1  result register holds a valid result
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  WIDTH  `a | b` of the granted pair
- `res_id`  out  IDW  index of the requester that produced `res_data`
- `busy`  out  1  equals `res_valid`

## Operation
- Output stage is a one-entry FSM: EMPTY (`res_valid`=0) or FULL (`res_valid`=1).
- `can_accept` = EMPTY, or FULL with `res_ready`=1.
- Arbitration is combinational. Scan `req_valid` starting at pointer `rr_ptr` and wrapping modulo `NREQ`. The first set bit is the winner `g`.
- `req_ready[g]`=1 only when `can_accept`=1; all other bits are 0. `req_ready` depends on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- Transfer for requester i occurs when `req_valid[i]` and `req_ready[i]` are both 1.
- On transfer:
  - `res_data` <= `req_a[g] | req_b[g]`
  - `res_id` <= g
  - FSM → FULL
  - `rr_ptr` <= (g+1) mod `NREQ`
- FULL with `res_ready`=1 and no transfer → EMPTY. `res_data`/`res_id` keep their last values.
- FULL with `res_ready`=0: hold `res_data` and `res_id` stable and grant nobody.
- `rr_ptr` changes only on a transfer.
- Requesters hold `a`/`b`/`req_valid` until transfer. The block does not check this.

## Timing
- Reset values: `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0, `rr_ptr`=0, FSM=EMPTY.
- `req_ready` is 0 while `reset`=1.
- Latency: transfer in cycle N → `res_valid`=1 with data in cycle N+1.
- Throughput: 1 result per cycle while `res_ready`=1.
- Simultaneous drain and fill (FULL, `res_ready`=1, transfer): the old result is consumed and the new one is loaded in the same edge. `res_valid` stays 1.
- Pointer wrap: a grant to `NREQ`-1 sets `rr_ptr`=0.
- No `req_valid` set: no grant, `rr_ptr` unchanged.
- Reset mid-operation: any pending result is dropped without handshake, and `rr_ptr` returns to 0 on the next edge.

## Configuration
- `OR_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest set index of `req_valid` always wins, and `rr_ptr` is not implemented.
- Not defined (default): round-robin as described in Operation.
- All other behaviour, timing and reset values are identical in both builds.

## Test plan
- Reset: assert `reset` for 2 cycles with `req_valid`=4'b1111 → `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0 throughout.
- Single request: `req_valid`=4'b0100, `req_a[2]`=8'hA0, `req_b[2]`=8'h0C, `res_ready`=1 → `req_ready`=4'b0100 in cycle N; cycle N+1 shows `res_valid`=1, `res_data`=8'hAC, `res_id`=2.
- Round-robin fairness: all four valid, `res_ready`=1 for 8 cycles → grants 0,1,2,3,0,1,2,3 with back-to-back `res_valid`. With `OR_ARB_FIXED_PRIO_EN` → grant 0 every cycle.
- Backpressure: FULL with `res_data`=8'h5A, `res_ready`=0 for 3 cycles, requests pending → `req_ready`=0 and `res_data`/`res_id` stable. Raise `res_ready` → same-cycle grant, and the new result appears next cycle.
- Wrap/skip: `rr_ptr`=3 and `req_valid`=4'b0010 → grant 1, then `rr_ptr`=2. Next grant to 3 → `rr_ptr`=0.
- Reset mid-flight: FULL with `res_ready`=0, then pulse `reset` → `res_valid`=0 next cycle. The following request from requester 3 is granted only after requesters 0..2 are checked (`rr_ptr`=0).
